instruction_fetch_stage: RTL and testbench

//  MIPS IF stage plus the IF/ID pipeline register, directly upstream of the decode Controller.

---
 rtl/instruction_fetch_stage.sv | 106 ++++++++++
 tb/tb_instruction_fetch_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage with the IF/ID pipeline register.
// Selects next PC (branch > jump > jr > stall > sequential) and slices decode fields for ID.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BrTaken,
    input  logic [31:0] BrTarget,
    input  logic        JumpControl,
    input  logic        JRegControl,
    input  logic [31:0] JRegTarget,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemData,
    output logic [31:0] PC,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid,
    output logic [5:0]  readOp,
    output logic [4:0]  readRS,
    output logic [4:0]  readRT,
    output logic [4:0]  read10_6,
    output logic [5:0]  read5_0,
    output logic        FlushIdEx,
    output logic [31:0] FetchCount,
    output logic        AlignErr
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pcp4;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;
    logic        r_align_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_redir_target;
    logic        w_jump_ok;
    logic        w_jreg_ok;
    logic        w_redirect;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_jump_target = {r_ifid_pcp4[31:28], r_ifid_instr[25:0], 2'b00};

    // ID-stage jumps only count for a real instruction that is actually advancing;
    // the AND with a known-zero qualifier also masks X on the control inputs.
    assign w_jump_ok = r_ifid_valid & ~Stall & JumpControl;
    assign w_jreg_ok = r_ifid_valid & ~Stall & JRegControl;

    always_comb begin
        w_redirect     = 1'b0;
        w_redir_target = w_pc_plus4;
        if (BrTaken) begin
            w_redirect     = 1'b1;
            w_redir_target = BrTarget;
        end else if (w_jump_ok) begin
            w_redirect     = 1'b1;
            w_redir_target = w_jump_target;
        end else if (w_jreg_ok) begin
            w_redirect     = 1'b1;
            w_redir_target = JRegTarget;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc          <= RESET_PC;
            r_ifid_instr  <= NOP_WORD;
            r_ifid_pcp4   <= 32'd0;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= 32'd0;
            r_align_err   <= 1'b0;
        end else if (w_redirect) begin
            // No delay slot: the word fetched this cycle is dropped for a bubble.
            r_pc         <= {w_redir_target[31:2], 2'b00};
            r_ifid_instr <= NOP_WORD;
            r_ifid_valid <= 1'b0;
            if (w_redir_target[1:0] != 2'b00) r_align_err <= 1'b1;
        end else if (!Stall) begin
            r_pc          <= w_pc_plus4;
            r_ifid_instr  <= ImemData;
            r_ifid_pcp4   <= w_pc_plus4;
            r_ifid_valid  <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign ImemAddr    = r_pc;
    assign PC          = r_pc;
    assign IfIdInstr   = r_ifid_instr;
    assign IfIdPCPlus4 = r_ifid_pcp4;
    assign IfIdValid   = r_ifid_valid;
    assign FetchCount  = r_fetch_count;
    assign AlignErr    = r_align_err;
    assign FlushIdEx   = BrTaken;

    assign readOp   = r_ifid_instr[31:26];
    assign readRS   = r_ifid_instr[25:21];
    assign readRT   = r_ifid_instr[20:16];
    assign read10_6 = r_ifid_instr[10:6];
    assign read5_0  = r_ifid_instr[5:0];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios then random traffic against a
// cycle-level reference model of the fetch rules.
module tb_instruction_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst, Stall, BrTaken, JumpControl, JRegControl;
    logic [31:0] BrTarget, JRegTarget, ImemData;
    logic [31:0] ImemAddr, PC, IfIdInstr, IfIdPCPlus4, FetchCount;
    logic        IfIdValid, FlushIdEx, AlignErr;
    logic [5:0]  readOp, read5_0;
    logic [4:0]  readRS, readRT, read10_6;

    int n_checks = 0;
    int n_fails  = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
    logic        m_valid, m_err;

    always #5 Clk = ~Clk;

    instruction_fetch_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .BrTaken(BrTaken), .BrTarget(BrTarget),
        .JumpControl(JumpControl), .JRegControl(JRegControl), .JRegTarget(JRegTarget),
        .ImemAddr(ImemAddr), .ImemData(ImemData), .PC(PC), .IfIdInstr(IfIdInstr),
        .IfIdPCPlus4(IfIdPCPlus4), .IfIdValid(IfIdValid), .readOp(readOp), .readRS(readRS),
        .readRT(readRT), .read10_6(read10_6), .read5_0(read5_0), .FlushIdEx(FlushIdEx),
        .FetchCount(FetchCount), .AlignErr(AlignErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        Rst = 1'b0; Stall = 1'b0; BrTaken = 1'b0; JumpControl = 1'b0; JRegControl = 1'b0;
        BrTarget = 32'd0; JRegTarget = 32'd0;
    endtask

    // Advance one clock: predict from the rules, then compare every output.
    task automatic tick();
        logic [31:0] tgt;
        logic        redir;
        chk("ImemAddr", ImemAddr, m_pc);
        chk("FlushIdEx", {31'd0, FlushIdEx}, {31'd0, BrTaken});
        redir = 1'b0;
        tgt   = 32'd0;
        if (Rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0;
            m_cnt = 32'd0; m_err = 1'b0;
        end else begin
            if (BrTaken) begin
                redir = 1'b1; tgt = BrTarget;
            end else if (m_valid && !Stall && JumpControl === 1'b1) begin
                redir = 1'b1; tgt = {m_pcp4[31:28], m_instr[25:0], 2'b00};
            end else if (m_valid && !Stall && JRegControl === 1'b1) begin
                redir = 1'b1; tgt = JRegTarget;
            end
            if (redir) begin
                m_pc    = tgt - (tgt % 4);
                m_instr = 32'd0;
                m_valid = 1'b0;
                if (tgt % 4 != 0) m_err = 1'b1;
            end else if (!Stall) begin
                m_instr = ImemData;
                m_pcp4  = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
        end
        @(posedge Clk);
        #1;
        chk("PC", PC, m_pc);
        chk("IfIdInstr", IfIdInstr, m_instr);
        chk("IfIdPCPlus4", IfIdPCPlus4, m_pcp4);
        chk("IfIdValid", {31'd0, IfIdValid}, {31'd0, m_valid});
        chk("FetchCount", FetchCount, m_cnt);
        chk("AlignErr", {31'd0, AlignErr}, {31'd0, m_err});
        chk("fields", {readOp, readRS, readRT, read10_6, read5_0},
            {m_instr[31:26], m_instr[25:21], m_instr[20:16], m_instr[10:6], m_instr[5:0]});
    endtask

    initial begin
        idle_inputs();
        ImemData = 32'h2008_0005;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        m_pc = 32'd0; m_instr = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0;
        m_cnt = 32'd0; m_err = 1'b0;
        chk("rst_PC", PC, 32'd0);
        chk("rst_valid", {31'd0, IfIdValid}, 32'd0);
        chk("rst_count", FetchCount, 32'd0);
        chk("rst_instr", IfIdInstr, 32'd0);
        tick();

        // 1: free run
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t1_PC", PC, 32'h10);
        chk("t1_count", FetchCount, 32'd4);
        chk("t1_instr", IfIdInstr, 32'h2008_0005);

        // 2: stall at PC=8
        Rst = 1'b1; tick(); Rst = 1'b0;
        tick(); tick();
        chk("t2_pc8", PC, 32'h8);
        Stall = 1'b1; ImemData = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) tick();
        chk("t2_frozen_pc", PC, 32'h8);
        chk("t2_frozen_cnt", FetchCount, 32'd2);
        Stall = 1'b0; tick();
        chk("t2_resume", PC, 32'hC);

        // 3: j with index 0x10 fetched at PC=4
        Rst = 1'b1; tick(); Rst = 1'b0;
        ImemData = 32'h0000_0000; tick();
        ImemData = 32'h0800_0010; tick();
        chk("t3_pcp4", IfIdPCPlus4, 32'h8);
        JumpControl = 1'b1; tick(); JumpControl = 1'b0;
        chk("t3_pc", PC, 32'h40);
        chk("t3_bubble", {31'd0, IfIdValid}, 32'd0);
        // X on jump controls while IF/ID holds a bubble must be ignored
        JumpControl = 1'bx; JRegControl = 1'bx; ImemData = 32'h1234_5678; tick();
        JumpControl = 1'b0; JRegControl = 1'b0;
        chk("t3_xign", PC, 32'h44);

        // 4: branch beats stall and jump
        BrTaken = 1'b1; BrTarget = 32'h100; Stall = 1'b1; JumpControl = 1'b1;
        chk("t4_flush", {31'd0, FlushIdEx}, 32'd1);
        tick();
        idle_inputs();
        chk("t4_pc", PC, 32'h100);
        chk("t4_bubble", IfIdInstr, 32'd0);

        // 5: misaligned jr
        tick();
        JRegControl = 1'b1; JRegTarget = 32'h203; tick(); JRegControl = 1'b0;
        chk("t5_pc", PC, 32'h200);
        chk("t5_err", {31'd0, AlignErr}, 32'd1);
        tick(); tick();
        chk("t5_sticky", {31'd0, AlignErr}, 32'd1);

        // 6: wrap, then reset during stall
        BrTaken = 1'b1; BrTarget = 32'hFFFF_FFFC; tick(); BrTaken = 1'b0;
        tick();
        chk("t6_wrap", PC, 32'h0);
        Stall = 1'b1; tick(); Rst = 1'b1; tick();
        idle_inputs();
        chk("t6_rst_pc", PC, 32'h0);
        chk("t6_rst_err", {31'd0, AlignErr}, 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            Rst         = ($urandom_range(0, 99) == 0);
            Stall       = ($urandom_range(0, 3) == 0);
            BrTaken     = ($urandom_range(0, 9) == 0);
            JumpControl = ($urandom_range(0, 7) == 0);
            JRegControl = ($urandom_range(0, 7) == 0);
            BrTarget    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            JRegTarget  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                BrTarget[1:0]   = 2'b00;
                JRegTarget[1:0] = 2'b00;
            end
            ImemData = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
